// File: rtl/rsa_cmd_wrapper_param_if.sv
// Bundle of every signal between the RSA command wrapper, the ARM glue and
// the start/done exponentiation core.
//
// Handshake rules: a word moves on a rising clock edge where the sender's
// valid and the receiver's ready are both 1. A sender may not withdraw
// valid or change its data until that edge. The wrapper's ready/valid/done/
// core_start outputs are decoded from its registered state only, so they
// never depend combinationally on inputs. cmd_valid and done_read are
// single-cycle strobes sampled only in the states that consume them.
interface rsa_cmd_wrapper_param_if #(
  parameter int W      = 1024,
  parameter int NPARAM = 5
);
  logic [31:0]         arm_to_fpga_cmd;
  logic                arm_to_fpga_cmd_valid;
  logic                fpga_to_arm_done;
  logic                fpga_to_arm_done_read;
  logic [3:0]          fpga_to_arm_status;
  logic                arm_to_fpga_data_valid;
  logic                arm_to_fpga_data_ready;
  logic [W-1:0]        arm_to_fpga_data;
  logic                fpga_to_arm_data_valid;
  logic                fpga_to_arm_data_ready;
  logic [W-1:0]        fpga_to_arm_data;
  logic                core_start;
  logic [NPARAM*W-1:0] core_params;
  logic                core_done;
  logic [W-1:0]        core_result;
  logic [3:0]          leds;

  // Wrapper side.
  modport slave (
    input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
    input  arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    input  core_done, core_result,
    output fpga_to_arm_done, fpga_to_arm_status, arm_to_fpga_data_ready,
    output fpga_to_arm_data_valid, fpga_to_arm_data, core_start, core_params,
    output leds
  );

  // ARM glue plus core side.
  modport master (
    output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
    output arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    output core_done, core_result,
    input  fpga_to_arm_done, fpga_to_arm_status, arm_to_fpga_data_ready,
    input  fpga_to_arm_data_valid, fpga_to_arm_data, core_start, core_params,
    input  leds
  );
endinterface

// File: rtl/rsa_cmd_wrapper_param.sv
// RSA command wrapper: decodes ARM commands, loads operands into addressed
// parameter slots, runs a start/done core with a timeout, buffers the result
// and returns it on request. Every command ends in DONE with a status code.
module rsa_cmd_wrapper_param #(
  parameter int W              = 1024,
  parameter int NPARAM         = 5,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input logic                     clk,
  input logic                     reset,
  rsa_cmd_wrapper_param_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] ST_OK       = 4'd0;
  localparam logic [3:0] ST_ILLEGAL  = 4'd1;
  localparam logic [3:0] ST_BAD_SLOT = 4'd2;
  localparam logic [3:0] ST_MISSING  = 4'd3;
  localparam logic [3:0] ST_TIMEOUT  = 4'd4;
  localparam logic [3:0] ST_NO_RES   = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [3:0]          status_r, status_n;
  logic [7:0]          slot_r;
  logic [NPARAM*W-1:0] params_r;
  logic [NPARAM-1:0]   slot_valid;
  logic [W-1:0]        result_r;
  logic                result_valid;
  logic [CNT_W-1:0]    cnt;

  logic       latch_slot, write_slot, latch_result, clear_slots, clear_result;
  logic [7:0] opcode, cmd_slot;
  logic       slot_ok, timeout_hit;
  logic       cmd_unused;

  assign opcode      = bus.arm_to_fpga_cmd[7:0];
  assign cmd_slot    = bus.arm_to_fpga_cmd[15:8];
  assign cmd_unused  = ^bus.arm_to_fpga_cmd[31:16];
  assign slot_ok     = ({24'd0, cmd_slot} < 32'(NPARAM));
  // A zero TIMEOUT_CYCLES disables the abort entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // State and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      status_r <= ST_OK;
    end else begin
      state    <= state_n;
      status_r <= status_n;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_n      = state;
    status_n     = status_r;
    latch_slot   = 1'b0;
    write_slot   = 1'b0;
    latch_result = 1'b0;
    clear_slots  = 1'b0;
    clear_result = 1'b0;
    case (state)
      S_IDLE: begin
        status_n = ST_OK;
        if (bus.arm_to_fpga_cmd_valid) begin
          case (opcode)
            8'h00: begin
              if (slot_ok) begin
                state_n    = S_LOAD;
                latch_slot = 1'b1;
              end else begin
                state_n  = S_DONE;
                status_n = ST_BAD_SLOT;
              end
            end
            8'h01: begin
              if (&slot_valid) begin
                state_n      = S_START;
                clear_result = 1'b1;
              end else begin
                state_n  = S_DONE;
                status_n = ST_MISSING;
              end
            end
            8'h02: begin
              if (result_valid) begin
                state_n = S_SEND;
              end else begin
                state_n  = S_DONE;
                status_n = ST_NO_RES;
              end
            end
            8'h03: begin
              clear_slots  = 1'b1;
              clear_result = 1'b1;
              state_n      = S_DONE;
            end
            default: begin
              state_n  = S_DONE;
              status_n = ST_ILLEGAL;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (bus.arm_to_fpga_data_valid) begin
          write_slot = 1'b1;
          state_n    = S_DONE;
          status_n   = ST_OK;
        end
      end
      S_START: state_n = S_BUSY;
      S_BUSY: begin
        // A completion in the same cycle as the timeout still counts.
        if (bus.core_done) begin
          latch_result = 1'b1;
          state_n      = S_DONE;
          status_n     = ST_OK;
        end else if (timeout_hit) begin
          state_n  = S_DONE;
          status_n = ST_TIMEOUT;
        end
      end
      S_SEND: begin
        if (bus.fpga_to_arm_data_ready) begin
          state_n  = S_DONE;
          status_n = ST_OK;
        end
      end
      S_DONE: begin
        if (bus.fpga_to_arm_done_read) begin
          state_n  = S_IDLE;
          status_n = ST_OK;
        end
      end
      default: begin
        state_n  = S_IDLE;
        status_n = ST_OK;
      end
    endcase
  end

  // Slot index captured with a LOAD command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           slot_r <= 8'd0;
    else if (latch_slot) slot_r <= cmd_slot;
  end

  // Parameter slots and their valid mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      params_r   <= '0;
      slot_valid <= '0;
    end else if (clear_slots) begin
      slot_valid <= '0;
    end else if (write_slot) begin
      for (int k = 0; k < NPARAM; k++) begin
        if (slot_r == 8'(k)) begin
          params_r[k*W +: W] <= bus.arm_to_fpga_data;
          slot_valid[k]      <= 1'b1;
        end
      end
    end
  end

  // Result buffer; a late core_done outside BUSY never reaches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r     <= '0;
      result_valid <= 1'b0;
    end else if (clear_result) begin
      result_valid <= 1'b0;
    end else if (latch_result) begin
      result_r     <= bus.core_result;
      result_valid <= 1'b1;
    end
  end

  // Saturating BUSY cycle counter for the compute timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cnt <= '0;
    else if (state == S_START)                   cnt <= '0;
    else if (state == S_BUSY && cnt != CNT_TERM) cnt <= cnt + 1'b1;
  end

  assign bus.fpga_to_arm_done       = (state == S_DONE);
  assign bus.fpga_to_arm_status     = status_r;
  assign bus.arm_to_fpga_data_ready = (state == S_LOAD);
  assign bus.fpga_to_arm_data_valid = (state == S_SEND);
  assign bus.fpga_to_arm_data       = result_r;
  assign bus.core_start             = (state == S_START);
  assign bus.core_params            = params_r;
  assign bus.leds                   = {result_valid, state};

endmodule
